// File: rtl/register_read_serializer_if.sv
// rtl/register_read_serializer_if.sv - load and serial-bit handshake bundle for the read serializer
interface register_read_serializer_if #(
  parameter int WIDTH = 32
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;
  logic             first_bit;
  logic             done;

  modport slave (
    input  load_valid, load_data, bit_ready,
    output load_ready, bit_out, bit_valid, first_bit, done
  );

  modport master (
    output load_valid, load_data, bit_ready,
    input  load_ready, bit_out, bit_valid, first_bit, done
  );
endinterface

// File: rtl/register_read_serializer.sv
// rtl/register_read_serializer.sv - streams a captured register word out one bit per accepted beat
module register_read_serializer #(
  parameter int WIDTH     = 32,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clock,
  input  logic                     clear_n,
  register_read_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    count_q, count_d;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
    end
  end

  // Shifting toward the output end with zero fill leaves sreg all-zero once the frame ends.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          sreg_d  = bus.load_data;
          count_d = COUNT_FULL;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_ready) begin
          sreg_d  = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, sreg_q[WIDTH-1:1]};
          count_d = count_q - COUNT_ONE;
          if (count_q == COUNT_ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready = (state_q == IDLE);
    bus.bit_valid  = (state_q == SHIFT);
    bus.done       = (state_q == DONE);
    bus.first_bit  = (state_q == SHIFT) && (count_q == COUNT_FULL);
    bus.bit_out    = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
  end

endmodule

// File: tb/tb_register_read_serializer.sv
// tb/tb_register_read_serializer.sv - scoreboard bench for register_read_serializer
module tb_register_read_serializer;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  register_read_serializer_if #(.WIDTH(32)) a();
  register_read_serializer_if #(.WIDTH(8))  b();

  register_read_serializer #(.WIDTH(32), .MSB_FIRST(1)) dut32 (
    .clock(clk), .clear_n(clear_n), .bus(a)
  );
  register_read_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
    .clock(clk), .clear_n(clear_n), .bus(b)
  );

  typedef struct packed {
    logic b;
    logic f;
  } beat_t;

  beat_t q32[$];
  beat_t q8[$];
  int    frames32[$];
  int    frames8[$];
  beat_t e32, e8;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    beats32 = 0;
  int    beats8 = 0;
  bit    alt_en = 1'b0;
  bit    stall_pend = 1'b0;
  logic  stall_bit, stall_first;
  bit    prev_done32 = 1'b0;
  int    cnt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push32(logic [31:0] w);
    beat_t e;
    for (int i = 0; i < 32; i++) begin
      e.b = w[31-i];
      e.f = (i == 0);
      q32.push_back(e);
    end
    frames32.push_back(32);
  endtask

  task automatic push8(logic [7:0] w);
    beat_t e;
    for (int i = 0; i < 8; i++) begin
      e.b = w[i];
      e.f = (i == 0);
      q8.push_back(e);
    end
    frames8.push_back(8);
  endtask

  always @(posedge clk) begin
    if (alt_en) begin
      #1 a.bit_ready = ~a.bit_ready;
    end
  end

  always @(negedge clk) begin
    if (!clear_n) begin
      beats32     = 0;
      stall_pend  = 1'b0;
      prev_done32 = 1'b0;
    end else begin
      if (prev_done32) check("ready_after_done", {31'd0, a.load_ready}, 32'd1);
      prev_done32 = a.done;
      if (stall_pend) begin
        check("stall_bit_stable", {31'd0, a.bit_out}, {31'd0, stall_bit});
        check("stall_first_stable", {31'd0, a.first_bit}, {31'd0, stall_first});
        stall_pend = 1'b0;
      end
      if (a.bit_valid && a.bit_ready) begin
        if (q32.size() == 0) begin
          check("unexpected_beat32", 32'd1, 32'd0);
        end else begin
          e32 = q32.pop_front();
          check("bit32", {31'd0, a.bit_out}, {31'd0, e32.b});
          check("first32", {31'd0, a.first_bit}, {31'd0, e32.f});
        end
        beats32++;
      end else if (a.bit_valid) begin
        stall_bit   = a.bit_out;
        stall_first = a.first_bit;
        stall_pend  = 1'b1;
      end
      if (a.done) begin
        check("done_no_valid32", {31'd0, a.bit_valid}, 32'd0);
        check("done_no_ready32", {31'd0, a.load_ready}, 32'd0);
        if (frames32.size() == 0) check("unexpected_done32", 32'd1, 32'd0);
        else check("done_beats32", beats32, frames32.pop_front());
        beats32 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!clear_n) begin
      beats8 = 0;
    end else begin
      if (b.bit_valid && b.bit_ready) begin
        if (q8.size() == 0) begin
          check("unexpected_beat8", 32'd1, 32'd0);
        end else begin
          e8 = q8.pop_front();
          check("bit8", {31'd0, b.bit_out}, {31'd0, e8.b});
          check("first8", {31'd0, b.first_bit}, {31'd0, e8.f});
        end
        beats8++;
      end
      if (b.done) begin
        check("done_no_valid8", {31'd0, b.bit_valid}, 32'd0);
        if (frames8.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
        else check("done_beats8", beats8, frames8.pop_front());
        beats8 = 0;
      end
    end
  end

  task automatic load32(logic [31:0] w);
    @(posedge clk);
    #1;
    a.load_valid = 1'b1;
    a.load_data  = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a.load_ready) break;
    end
    check("load32_ready", {31'd0, a.load_ready}, 32'd1);
    push32(w);
    @(posedge clk);
    #1 a.load_valid = 1'b0;
  endtask

  task automatic wait_idle32();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (a.load_ready && q32.size() == 0 && frames32.size() == 0) break;
    end
    check("idle32", {31'd0, (a.load_ready && q32.size() == 0 && frames32.size() == 0)}, 32'd1);
  endtask

  initial begin
    a.load_valid = 1'b0; a.load_data = '0; a.bit_ready = 1'b0;
    b.load_valid = 1'b0; b.load_data = '0; b.bit_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_load_ready", {31'd0, a.load_ready}, 32'd1);
    check("rst_bit_valid", {31'd0, a.bit_valid}, 32'd0);
    check("rst_first_bit", {31'd0, a.first_bit}, 32'd0);
    check("rst_done", {31'd0, a.done}, 32'd0);
    check("rst_bit_out", {31'd0, a.bit_out}, 32'd0);
    check("rst_load_ready8", {31'd0, b.load_ready}, 32'd1);
    #1 clear_n = 1'b1;

    // 1: full-rate frame with latency checks
    a.bit_ready = 1'b1;
    load32(32'hA5A5_0F0F);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        check("lat_valid", {31'd0, a.bit_valid}, 32'd1);
        check("lat_first", {31'd0, a.first_bit}, 32'd1);
      end
      if (a.done) break;
    end
    check("done_cycle", cnt, 33);
    wait_idle32();

    // 2: alternating bit_ready
    alt_en = 1'b1;
    load32(32'hA5A5_0F0F);
    wait_idle32();
    alt_en = 1'b0;
    @(posedge clk);
    #2 a.bit_ready = 1'b1;

    // 3: load_valid during SHIFT is ignored
    load32(32'h0000_0000);
    repeat (3) @(posedge clk);
    #1;
    a.load_valid = 1'b1;
    a.load_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a.done) break;
    end
    a.load_valid = 1'b0;
    wait_idle32();

    // 4: mid-frame reset, then restart right after release
    load32(32'h1234_5678);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (beats32 >= 10) break;
    end
    check("beats_before_reset", beats32, 10);
    @(posedge clk);
    #1 clear_n = 1'b0;
    #1;
    check("abort_bit_valid", {31'd0, a.bit_valid}, 32'd0);
    check("abort_done", {31'd0, a.done}, 32'd0);
    check("abort_load_ready", {31'd0, a.load_ready}, 32'd1);
    check("abort_first_bit", {31'd0, a.first_bit}, 32'd0);
    q32.delete();
    frames32.delete();
    repeat (2) @(negedge clk);
    #1;
    a.load_valid = 1'b1;
    a.load_data  = 32'hF000_0001;
    push32(32'hF000_0001);
    clear_n = 1'b1;
    @(posedge clk);
    #1 a.load_valid = 1'b0;
    @(negedge clk);
    check("restart_valid", {31'd0, a.bit_valid}, 32'd1);
    check("restart_first", {31'd0, a.first_bit}, 32'd1);
    wait_idle32();

    // 5: WIDTH=8, LSB first
    b.bit_ready = 1'b1;
    @(posedge clk);
    #1;
    b.load_valid = 1'b1;
    b.load_data  = 8'h01;
    push8(8'h01);
    @(posedge clk);
    #1 b.load_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (b.load_ready && q8.size() == 0 && frames8.size() == 0) break;
    end
    check("idle8", {31'd0, (b.load_ready && q8.size() == 0 && frames8.size() == 0)}, 32'd1);

    // 6: back-to-back loads with load_valid held high
    @(posedge clk);
    #1;
    a.load_valid = 1'b1;
    a.load_data  = 32'h0000_0001;
    push32(32'h0000_0001);
    @(posedge clk);
    #1;
    a.load_data = 32'h8000_0000;
    push32(32'h8000_0000);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (a.load_ready) break;
    end
    check("b2b_spacing", cnt, 34);
    @(posedge clk);
    #1 a.load_valid = 1'b0;
    wait_idle32();

    repeat (3) @(negedge clk);
    check("final_q32_empty", q32.size(), 0);
    check("final_q8_empty", q8.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
